// File: rtl/half_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module : hs_pkg
// Brief  : Shared defaults, lane result type and truth-table constants for
//          the registered vectorised half subtractor.
// Rev    : 1.0
// ============================================================================
package hs_pkg;

  localparam int HS_WIDTH_DEF = 1;
  localparam int HS_CNT_W_DEF = 16;

  typedef struct packed {
    logic diff;
    logic borrow;
  } hs_lane_t;

  // Indexed by {a, b}: entry 1 is (a=0,b=1), entry 2 is (a=1,b=0).
  localparam logic [3:0] HS_TT_DIFF   = 4'b0110;
  localparam logic [3:0] HS_TT_BORROW = 4'b0010;

  function automatic hs_lane_t hs_eval(input logic a, input logic b);
    hs_lane_t r;
    r.diff   = a ^ b;
    r.borrow = ~a & b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module : half_subtractor_if
// Brief  : Input/result bundle for half_subtractor; borrow_cnt exists only
//          when HS_BORROW_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
interface half_subtractor_if
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH_DEF
`ifdef HS_BORROW_CNT_EN
  ,
  parameter int CNT_W = HS_CNT_W_DEF
`endif
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
`ifdef HS_BORROW_CNT_EN
  logic [CNT_W-1:0] borrow_cnt;

  modport master (output in_valid, a, b,
                  input  out_valid, diff, borrow, borrow_cnt);
  modport slave  (input  in_valid, a, b,
                  output out_valid, diff, borrow, borrow_cnt);
`else
  modport master (output in_valid, a, b,
                  input  out_valid, diff, borrow);
  modport slave  (input  in_valid, a, b,
                  output out_valid, diff, borrow);
`endif

endinterface
`default_nettype wire

// File: rtl/half_subtractor_bit.sv
`default_nettype none
// ============================================================================
// Module : hs_bit
// Brief  : Purely combinational single-lane half subtractor.
// Rev    : 1.0
// ============================================================================
module hs_bit
  import hs_pkg::*;
(
  input  wire logic a,
  input  wire logic b,
  output logic      diff,
  output logic      borrow
);

  hs_lane_t lane;

  assign lane   = hs_eval(a, b);
  assign diff   = lane.diff;
  assign borrow = lane.borrow;

endmodule
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ============================================================================
// Module : half_subtractor
// Brief  : Registered per-lane half subtractor with valid qualifier; optional
//          saturating borrow-event counter under HS_BORROW_CNT_EN.
// Rev    : 1.0
// ============================================================================
module half_subtractor
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH_DEF
`ifdef HS_BORROW_CNT_EN
  ,
  parameter int CNT_W = HS_CNT_W_DEF
`endif
) (
  input  wire logic         clk,
  input  wire logic         rst,
  half_subtractor_if.slave  bus
);

  logic [WIDTH-1:0] lane_diff;
  logic [WIDTH-1:0] lane_borrow;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    hs_bit u_bit (
      .a      (bus.a[i]),
      .b      (bus.b[i]),
      .diff   (lane_diff[i]),
      .borrow (lane_borrow[i])
    );
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] diff_d,      diff_q;
  logic [WIDTH-1:0] borrow_d,    borrow_q;

  // Results hold when idle; consumers qualify them with out_valid.
  always_comb begin
    out_valid_d = bus.in_valid;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    if (bus.in_valid) begin
      diff_d   = lane_diff;
      borrow_d = lane_borrow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

`ifdef HS_BORROW_CNT_EN
  logic [CNT_W-1:0] borrow_cnt_d, borrow_cnt_q;

  always_comb begin
    borrow_cnt_d = borrow_cnt_q;
    if (bus.in_valid && (|lane_borrow) && (borrow_cnt_q != {CNT_W{1'b1}})) begin
      borrow_cnt_d = borrow_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_cnt_q <= '0;
    end else begin
      borrow_cnt_q <= borrow_cnt_d;
    end
  end

  assign bus.borrow_cnt = borrow_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module : tb_half_subtractor
// Brief  : Bench for half_subtractor at WIDTH=1 and WIDTH=4 (counter CNT_W=2).
// Rev    : 1.0
// ============================================================================
module tb_half_subtractor;
  import hs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  half_subtractor_if #(.WIDTH(1)) bus1 ();
  half_subtractor_if #(.WIDTH(4)
`ifdef HS_BORROW_CNT_EN
    , .CNT_W(2)
`endif
  ) bus4 ();

  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  half_subtractor #(.WIDTH(4)
`ifdef HS_BORROW_CNT_EN
    , .CNT_W(2)
`endif
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state
  logic        m1_valid = 1'b0, m1_diff = 1'b0, m1_borrow = 1'b0;
  logic        m4_valid = 1'b0;
  logic [3:0]  m4_diff = '0, m4_borrow = '0;
  int          m1_cnt = 0, m4_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] tt_d, tt_b;
    logic [1:0] sub;
    logic [3:0] nd, nb;
    @(negedge clk);
    rst           = r;
    bus4.in_valid = v;
    bus4.a        = av;
    bus4.b        = bv;
    bus1.in_valid = v;
    bus1.a        = av[0];
    bus1.b        = bv[0];
    @(posedge clk);
    if (r) begin
      m1_valid = 1'b0; m1_diff = 1'b0; m1_borrow = 1'b0; m1_cnt = 0;
      m4_valid = 1'b0; m4_diff = '0;   m4_borrow = '0;   m4_cnt = 0;
    end else if (v) begin
      // single-lane model from the truth table
      tt_d = HS_TT_DIFF;
      tt_b = HS_TT_BORROW;
      m1_valid  = 1'b1;
      m1_diff   = tt_d[{av[0], bv[0]}];
      m1_borrow = tt_b[{av[0], bv[0]}];
      if (m1_borrow && m1_cnt < 65535) m1_cnt++;
      // four-lane model from 1-bit subtraction: {borrow, diff} = a - b
      for (int i = 0; i < 4; i++) begin
        sub   = {1'b0, av[i]} - {1'b0, bv[i]};
        nd[i] = sub[0];
        nb[i] = sub[1];
      end
      m4_valid  = 1'b1;
      m4_diff   = nd;
      m4_borrow = nb;
      if (nb != 4'd0 && m4_cnt < 3) m4_cnt++;
    end else begin
      m1_valid = 1'b0;
      m4_valid = 1'b0;
    end
    #1;
    vectors++;
    chk("w1_valid",  32'(bus1.out_valid), 32'(m1_valid));
    chk("w1_diff",   32'(bus1.diff),      32'(m1_diff));
    chk("w1_borrow", 32'(bus1.borrow),    32'(m1_borrow));
    chk("w4_valid",  32'(bus4.out_valid), 32'(m4_valid));
    chk("w4_diff",   32'(bus4.diff),      32'(m4_diff));
    chk("w4_borrow", 32'(bus4.borrow),    32'(m4_borrow));
`ifdef HS_BORROW_CNT_EN
    chk("w1_cnt", 32'(bus1.borrow_cnt), 32'(m1_cnt));
    chk("w4_cnt", 32'(bus4.borrow_cnt), 32'(m4_cnt));
`endif
  endtask

  initial begin
    logic [3:0] ra, rb;
    bus4.in_valid = 1'b1; bus4.a = 4'h1; bus4.b = 4'h0;
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;

    // Reset held two cycles with a live input, then one idle cycle after release
    step(1'b1, 1'b1, 4'h1, 4'h0);
    step(1'b1, 1'b1, 4'h1, 4'h0);
    step(1'b0, 1'b0, 4'h1, 4'h0);

    // Exhaustive lane-0 patterns 00, 01, 11, 10 with random upper lanes
    step(1'b0, 1'b1, {3'($urandom), 1'b0}, {3'($urandom), 1'b0});
    step(1'b0, 1'b1, {3'($urandom), 1'b0}, {3'($urandom), 1'b1});
    step(1'b0, 1'b1, {3'($urandom), 1'b1}, {3'($urandom), 1'b1});
    step(1'b0, 1'b1, {3'($urandom), 1'b1}, {3'($urandom), 1'b0});

    // Valid gating: outputs hold, out_valid drops
    step(1'b0, 1'b0, 4'h0, 4'hF);

    // Multi-lane directed vector
    step(1'b0, 1'b1, 4'b0011, 4'b0101);
    chk("w4_diff_dir",   32'(bus4.diff),   32'h6);
    chk("w4_borrow_dir", 32'(bus4.borrow), 32'h4);

    // Mid-stream reset drops the 10 input
    step(1'b0, 1'b1, 4'h0, 4'h1);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);

    // Five borrow-producing inputs drive the counter into saturation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0, 4'h1);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      step(($urandom_range(0, 19) == 0), 1'($urandom), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
